// File: rtl/serial_mem_loader_pkg.sv
// serial_mem_loader_pkg: shared state encoding and constants for the serial RAM loader.
package serial_mem_loader_pkg;
    typedef enum logic [2:0] {LD_IDLE, LD_ADDR, LD_CNT, LD_DATA, LD_RESP} ld_state_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [3:0] WE_FULL      = 4'b1111;
endpackage

// File: rtl/serial_mem_loader_byte_pack.sv
// ldr_byte_pack: MSB-first byte shift register with byte index and word_done strobe.
// last_idx_i selects the field length (1 -> 2-byte field, 3 -> 4-byte field).
module ldr_byte_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  last_idx_i,
    output logic [31:0] word_next_o,
    output logic        done_o
);
    logic [31:0] word_q;
    logic [1:0]  idx_q;

    assign word_next_o = {word_q[23:0], byte_i};
    assign done_o      = valid_i && idx_q == last_idx_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (valid_i) begin
            word_q <= word_next_o;
            idx_q  <= done_o ? 2'd0 : idx_q + 2'd1;
        end
    end
endmodule

// File: rtl/serial_mem_loader.sv
// serial_mem_loader: loads RAM words from a framed serial byte stream, holds the core
// in reset while loading and answers with an 8-bit checksum of the data bytes.
module serial_mem_loader
    import serial_mem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         TMO_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_dout_o,
    output logic [3:0]  mem_wr_en_o,
    output logic        core_hold_o,
    output logic        busy_o,
    output logic        err_o
);
    ld_state_t        state_q, state_d;
    logic [31:0]      addr_q, addr_d, mem_addr_q, mem_addr_d, mem_dout_q, mem_dout_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       wr_en_q, wr_en_d;
    logic             err_q, err_d;
    logic             in_frame, last_wr, acc, abort, done;
    logic [31:0]      word_next;

    ldr_byte_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == LD_IDLE),
        .valid_i    (acc),
        .byte_i     (rx_data),
        .last_idx_i (state_q == LD_CNT ? 2'd1 : 2'd3),
        .word_next_o(word_next),
        .done_o     (done)
    );

    assign in_frame = state_q == LD_ADDR || state_q == LD_CNT || state_q == LD_DATA;
    // Final word write cycle: the frame is complete, so no further byte is taken.
    assign last_wr  = state_q == LD_DATA && wr_en_q == WE_FULL && cnt_q == '0;
    assign acc      = rx_valid && in_frame && !last_wr;
    assign abort    = in_frame && !acc && !last_wr && tmo_q == TMO_W'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        wr_en_d    = '0;
        err_d      = 1'b0;
        tmo_d      = (acc || !in_frame) ? '0 : tmo_q + 1'b1;
        unique case (state_q)
            LD_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
                state_d = LD_ADDR;
                csum_d  = '0;
            end
            LD_ADDR: if (done) begin
                addr_d  = {word_next[31:2], 2'b00};
                state_d = LD_CNT;
            end
            LD_CNT: if (done) begin
                cnt_d   = word_next[15:0];
                state_d = word_next[15:0] == '0 ? LD_RESP : LD_DATA;
            end
            LD_DATA: begin
                if (acc) csum_d = csum_q + rx_data;
                if (done) begin
                    mem_dout_d = word_next;
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + 32'd4;
                    cnt_d      = cnt_q - 16'd1;
                    wr_en_d    = WE_FULL;
                end
                if (last_wr) state_d = LD_RESP;
            end
            LD_RESP: if (tx_ready) begin
                state_d = LD_IDLE;
                csum_d  = '0;
            end
            default: state_d = LD_IDLE;
        endcase
        if (abort) begin
            state_d = LD_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            wr_en_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
        end
    end

    assign tx_data     = csum_q;
    assign tx_valid    = state_q == LD_RESP;
    assign mem_addr_o  = mem_addr_q;
    assign mem_dout_o  = mem_dout_q;
    assign mem_wr_en_o = wr_en_q;
    assign core_hold_o = state_q != LD_IDLE;
    assign busy_o      = state_q != LD_IDLE;
    assign err_o       = err_q;
endmodule

// File: tb/tb_serial_mem_loader.sv
// tb_serial_mem_loader: directed frame vectors plus hand sequences for timeout,
// backpressure/address wrap and mid-frame reset.
module tb_serial_mem_loader;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] mem_addr_o, mem_dout_o;
    logic [3:0]  mem_wr_en_o;
    logic        core_hold_o, busy_o, err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    serial_mem_loader #(.TIMEOUT_CYC(TMO), .TMO_W(6)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o), .mem_wr_en_o(mem_wr_en_o),
        .core_hold_o(core_hold_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        logic [191:0] b;
        int           nw;
        logic [31:0]  a0, d0, a1, d1;
        logic [7:0]   cs;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en_o != 4'h0) begin
            chk("wr_en", {28'h0, mem_wr_en_o}, 32'hF);
            wa.push_back(mem_addr_o);
            wd.push_back(mem_dout_o);
        end
        if (err_o) err_cnt++;
    end

    task automatic send(input logic [191:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data  = b[8*(n-1-i) +: 8];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, output logic [7:0] d);
        int k = 0;
        while (!tx_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_resp_seen"}, {31'h0, tx_valid}, 32'h1);
        d = tx_data;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] d;
        wa.delete();
        wd.delete();
        send(v.b, v.n);
        wait_resp(v.name, d);
        chk({v.name, "_csum"}, {24'h0, d}, {24'h0, v.cs});
        chk({v.name, "_hold_in_resp"}, {31'h0, core_hold_o}, 32'h1);
        @(negedge clk);
        chk({v.name, "_hold_after"}, {31'h0, core_hold_o}, 32'h0);
        chk({v.name, "_txv_after"}, {31'h0, tx_valid}, 32'h0);
        chk({v.name, "_nwrites"}, wa.size(), v.nw);
        if (v.nw > 0 && wa.size() == v.nw) begin
            chk({v.name, "_a0"}, wa[0], v.a0);
            chk({v.name, "_d0"}, wd[0], v.d0);
            chk({v.name, "_alast"}, wa[v.nw-1], v.a1);
            chk({v.name, "_dlast"}, wd[v.nw-1], v.d1);
        end
    endtask

    initial begin
        logic [7:0] d, d0;
        int k;
        logic bad;
        vt[0] = '{"single", 11, {8'hA5, 32'h0000_0100, 16'h0001, 32'hDEAD_BEEF},
                  1, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF, 8'h38};
        vt[1] = '{"count0", 7, {8'hA5, 32'h0000_0010, 16'h0000},
                  0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00};
        vt[2] = '{"burst", 19, {8'hA5, 32'h0000_0003, 16'h0003,
                  96'h0102_0304_0506_0708_090A_0B0C},
                  3, 32'h0, 32'h0102_0304, 32'h8, 32'h090A_0B0C, 8'h4E};
        vt[3] = '{"sync_payload", 11, {8'hA5, 32'h0000_0020, 16'h0001, 32'hA5A5_A5A5},
                  1, 32'h20, 32'hA5A5_A5A5, 32'h20, 32'hA5A5_A5A5, 8'h94};

        #1;
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_txd", {24'h0, tx_data}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_dout", mem_dout_o, 32'h0);
        chk("rst_we", {28'h0, mem_wr_en_o}, 32'h0);
        chk("rst_flags", {29'h0, core_hold_o, busy_o, err_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        // timeout after two data bytes
        wa.delete();
        err_cnt = 0;
        send({8'hA5, 32'h0000_0040, 16'h0001, 16'h1122}, 9);
        chk("tmo_hold_busy", {31'h0, core_hold_o}, 32'h1);
        k = 0;
        while (!err_o && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency", k, TMO);
        chk("tmo_hold", {30'h0, core_hold_o, busy_o}, 32'h0);
        repeat (3) @(negedge clk);
        chk("tmo_err_pulses", err_cnt, 1);
        chk("tmo_nowrite", wa.size(), 0);
        run_vec(vt[0]);

        // backpressure with address wrap
        tx_ready = 1'b0;
        wa.delete();
        wd.delete();
        send({8'hA5, 32'hFFFF_FFFC, 16'h0002, 64'h1112_1314_1516_1718}, 15);
        wait_resp("bp", d0);
        chk("bp_csum", {24'h0, d0}, 32'hA4);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== d0) bad = 1'b1;
        end
        chk("bp_stable", {31'h0, bad}, 32'h0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", {30'h0, tx_valid, core_hold_o}, 32'h0);
        chk("bp_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("bp_a0", wa[0], 32'hFFFF_FFFC);
            chk("bp_d0", wd[0], 32'h1112_1314);
            chk("bp_a1", wa[1], 32'h0);
            chk("bp_d1", wd[1], 32'h1516_1718);
        end

        // reset mid-DATA, then junk in IDLE
        wa.delete();
        send({8'hA5, 32'h0000_0200, 16'h0001, 16'hAABB}, 9);
        chk("mid_busy", {31'h0, busy_o}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flags", {28'h0, tx_valid, core_hold_o, busy_o, err_o}, 32'h0);
        chk("mid_rst_txd", {24'h0, tx_data}, 32'h0);
        chk("mid_rst_addr", mem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send({8'h00, 8'hFF, 8'h5A}, 3);
        repeat (5) @(negedge clk);
        chk("junk_flags", {28'h0, tx_valid, core_hold_o, busy_o, err_o}, 32'h0);
        chk("junk_nowrite", wa.size(), 0);
        run_vec(vt[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
